// File: rtl/down_cnt_fsm_pkg.sv
// Shared definitions for the loadable down-counter control block:
// state encoding and its enumerated type.
package down_cnt_fsm_pkg;

    localparam int         STATE_BIT = 2;
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_RUN     = 2'b01;
    localparam logic [1:0] S_DONE    = 2'b10;

    typedef enum logic [STATE_BIT-1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/down_cnt_fsm.sv
// Loadable down-counter with IDLE/RUN/DONE control.
// A start request with a non-zero count opens a run window of exactly that
// many cycles, followed by a single-cycle done pulse, then a return to idle.
// Every output is a flop; the status flags are decoded from the next state
// so they line up with the state register.
module down_cnt_fsm
    import down_cnt_fsm_pkg::*;
#(
    parameter int CNT_BIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic               i_abort,
    output logic               o_idle,
    output logic               o_running,
    output logic               o_done,
    output logic [CNT_BIT-1:0] o_cnt
);

    localparam logic [CNT_BIT-1:0] CNT_ZERO = '0;
    localparam logic [CNT_BIT-1:0] CNT_ONE  = {{(CNT_BIT-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic [CNT_BIT-1:0] cnt_nxt;

    // Next-state and next-count decode; abort takes priority over the last count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = o_cnt;
        case (state)
            ST_IDLE: begin
                if (i_run && (i_num_cnt != CNT_ZERO)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = i_num_cnt;
                end else begin
                    cnt_nxt   = CNT_ZERO;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                end else if (o_cnt == CNT_ONE) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt   = o_cnt - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
            default: begin
                // Unreachable encodings recover to idle.
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, count and status flags registered together so they never skew.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            o_cnt     <= CNT_ZERO;
            o_idle    <= 1'b1;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_cnt     <= cnt_nxt;
            o_idle    <= (state_nxt == ST_IDLE);
            o_running <= (state_nxt == ST_RUN);
            o_done    <= (state_nxt == ST_DONE);
        end
    end

endmodule
